sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//  Initiator-side controller for the single-port synchronous SRAM (we/addr/din/dout).
//  Converts a valid/ready request channel (read or write) into correctly timed SRAM
//  port cycles and returns read data on a valid/ready response channel.
//  Sits between any bus master / test engine and the SRAM instance.
// PARAMETERS
//  ADDR_W  3  SRAM address width; depth = 2**ADDR_W
//  DATA_W  8  SRAM data width
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept (combinational: state==IDLE)
//  req_write  in   1       1=write, 0=read
//  req_addr   in   ADDR_W  request address
//  req_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       read data valid
//  rsp_ready  in   1       consumer accepts read data
//  rsp_rdata  out  DATA_W  read data
//  busy       out  1       init sequence in progress
//  mem_we     out  1       to SRAM we
//  mem_addr   out  ADDR_W  to SRAM addr
//  mem_din    out  DATA_W  to SRAM din
//  mem_dout   in   DATA_W  from SRAM dout (registered in SRAM, valid 1 cycle after addr sampled)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE (INIT with macro); mem_we=0, mem_addr=0, mem_din=0,
//    rsp_valid=0, rsp_rdata=0, busy=0; pending request/response discarded.
//  - All mem_* outputs registered. Request accepted when req_valid&&req_ready (cycle N).
//  - States: IDLE, RD_ADDR, RD_DATA, RSP (+INIT).
//  - Write in IDLE: cycle N+1 mem_we=1, mem_addr/mem_din = request; state stays IDLE,
//    so writes are accepted every cycle (throughput 1/clk). No response issued.
//    mem_we high exactly one cycle per accepted write, 0 otherwise.
//  - Read in IDLE: -> RD_ADDR (N+1: mem_addr=req_addr, mem_we=0) -> RD_DATA (N+2: mem_dout
//    valid) -> capture into rsp_rdata, -> RSP (N+3: rsp_valid=1). Latency 3 cycles.
//  - RSP: rsp_valid/rsp_rdata held stable until rsp_ready; on handshake -> IDLE,
//    rsp_valid=0 next cycle. req_ready=0 in every non-IDLE state (one read outstanding).
//  - Write at N then read same addr at N+1: write lands at N+1 edge, read sampled at N+3
//    edge -> returns new data (no hazard).
//  - rsp_ready high outside RSP: ignored. mem_din keeps last write value between writes.
// CONFIGURATION
//  SRAM_INIT_EN defined: reset state INIT; after rst_n release writes 0 to addr
//    0..2**ADDR_W-1, one per cycle (mem_we=1), busy=1, req_ready=0; then IDLE, busy=0.
//    Reset during INIT restarts at address 0.
//  SRAM_INIT_EN undefined: no INIT state, busy tied 0, req_ready=1 right after reset.
// STRUCTURE
//  sram_ctrl_pkg: state_t enum (IDLE, RD_ADDR, RD_DATA, RSP, INIT), default width consts
//  SRAM_ADDR_W_DEF=3, SRAM_DATA_W_DEF=8. Single module, no sub-module.
// TESTING (bench instantiates sram_ctrl + SRAM)
//  - Write 0xAA@0, 0x55@1 back-to-back -> req_ready stays 1, mem_we high 2 cycles.
//  - Read @0, @1 -> rsp_rdata 0xAA then 0x55, rsp_valid 3 cycles after each accept.
//  - Read @1 with rsp_ready=0 for 5 cycles -> rsp_valid/0x55 held, req_ready=0 throughout.
//  - Write 0x3C@5 then read @5 next cycle -> rsp_rdata=0x3C.
//  - rst_n low while in RD_DATA -> rsp_valid never rises, mem_we=0, req_ready=1 after release.
//  - SRAM_INIT_EN: busy high 8 cycles after reset; then read @7 -> 0x00.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the single-port SRAM initiator controller.
package sram_ctrl_pkg;

   localparam int unsigned SRAM_ADDR_W_DEF = 3;
   localparam int unsigned SRAM_DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      RSP     = 3'd3,
      INIT    = 3'd4
   } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Valid/ready request -> single-port synchronous SRAM cycles, read data returned on a response channel.
// Define SRAM_INIT_EN to zero-fill the whole SRAM after every reset (busy high meanwhile).
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = SRAM_ADDR_W_DEF,
   parameter int unsigned DATA_W = SRAM_DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t            state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef SRAM_INIT_EN
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] init_addr_q, init_addr_d;
`endif

   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
`ifdef SRAM_INIT_EN
      busy_d      = 1'b0;
      init_addr_d = init_addr_q;
`endif
      case (state_q)
         IDLE: begin
            // Writes stay in IDLE so a new request can be taken every cycle.
            if (req_valid) begin
               mem_addr_d = req_addr;
               if (req_write) begin
                  mem_we_d  = 1'b1;
                  mem_din_d = req_wdata;
               end else begin
                  state_d = RD_ADDR;
               end
            end
         end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            rsp_rdata_d = mem_dout;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         INIT: begin
`ifdef SRAM_INIT_EN
            mem_we_d    = 1'b1;
            mem_addr_d  = init_addr_q;
            mem_din_d   = '0;
            busy_d      = 1'b1;
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == '1) begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef SRAM_INIT_EN
         state_q     <= INIT;
         busy_q      <= 1'b0;
         init_addr_q <= '0;
`else
         state_q     <= IDLE;
`endif
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
`ifdef SRAM_INIT_EN
         busy_q      <= busy_d;
         init_addr_q <= init_addr_d;
`endif
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
`ifdef SRAM_INIT_EN
   assign busy      = busy_q;
`else
   assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl driving a behavioural registered-output SRAM; read data checked via a scoreboard queue.
module tb_sram_ctrl;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] sram [2**AW];

   int unsigned n_checks;
   int unsigned n_pass;
   logic [DW-1:0] exp_q [$];

   sram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   // Synchronous SRAM: dout registered, valid the cycle after addr is sampled.
   always_ff @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_din;
      mem_dout <= sram[mem_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = a;
      req_wdata = d;
      chk("wr_req_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
      chk("wr_mem_addr", {29'd0, mem_addr}, {29'd0, a});
      chk("wr_mem_din", {24'd0, mem_din}, {24'd0, d});
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int unsigned hold);
      int unsigned lat;
      logic [DW-1:0] e;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = a;
      rsp_ready = (hold == 0);
      chk("rd_req_ready", {31'd0, req_ready}, 32'd1);
      exp_q.push_back(exp);
      tick();
      req_valid = 1'b0;
      chk("rd_mem_addr", {29'd0, mem_addr}, {29'd0, a});
      chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rd_busy_ready", {31'd0, req_ready}, 32'd0);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!rsp_valid) begin
         chk("rd_rsp_timeout", {31'd0, rsp_valid}, 32'd1);
         exp_q.delete();
      end else begin
         chk("rd_latency", lat, 32'd3);
         for (int unsigned i = 0; i < hold; i++) begin
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q[0]});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
         end
         rsp_ready = 1'b1;
         e = exp_q.pop_front();
         chk("rd_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e});
         tick();
         chk("rd_rsp_drop", {31'd0, rsp_valid}, 32'd0);
         chk("rd_ready_back", {31'd0, req_ready}, 32'd1);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic wait_init();
`ifdef SRAM_INIT_EN
      int unsigned nbusy;
      nbusy = 0;
      for (int unsigned i = 0; i < 30; i++) begin
         tick();
         if (busy) nbusy++;
      end
      chk("init_busy_cycles", nbusy, 32'd8);
      chk("init_ready", {31'd0, req_ready}, 32'd1);
`else
      tick();
`endif
   endtask

   initial begin
      int unsigned rose;
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {29'd0, mem_addr}, 32'd0);
      chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SRAM_INIT_EN
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
`else
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
`endif
      rst_n = 1'b1;
      wait_init();
`ifdef SRAM_INIT_EN
      do_read(3'd7, 8'h00, 0);
`endif

      // Back-to-back writes, then mem_we must drop while mem_din holds.
      do_write(3'd0, 8'hAA);
      do_write(3'd1, 8'h55);
      req_valid = 1'b0;
      tick();
      chk("wr_idle_we", {31'd0, mem_we}, 32'd0);
      chk("wr_din_held", {24'd0, mem_din}, 32'h55);

      do_read(3'd0, 8'hAA, 0);
      do_read(3'd1, 8'h55, 0);
      do_read(3'd1, 8'h55, 5);

      do_write(3'd5, 8'h3C);
      do_read(3'd5, 8'h3C, 0);

      // Reset asserted while the read sits in RD_DATA.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 3'd1;
      rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      rose = 0;
      for (int unsigned i = 0; i < 12; i++) begin
         tick();
         if (rsp_valid) rose++;
      end
      chk("rstmid_never_valid", rose, 32'd0);
      chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rstmid_idle_we", {31'd0, mem_we}, 32'd0);
      rsp_ready = 1'b0;
`ifdef SRAM_INIT_EN
      do_read(3'd0, 8'h00, 0);
`else
      do_read(3'd0, 8'hAA, 0);
`endif
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
